// File: rtl/approx_mul_pkg.sv
// Shared types and helpers for the quadrant-split approximate multiplier.
package approx_mul_pkg;

    typedef enum logic [1:0] {
        EXACT = 2'b00,
        TRUNC = 2'b01,
        ZERO  = 2'b10,
        RSVD  = 2'b11
    } quad_mode_e;

    localparam int CFG_LL = 0;
    localparam int CFG_LH = 2;
    localparam int CFG_HL = 4;
    localparam int CFG_HH = 6;

    // Widest quadrant product the helper handles; callers cast down to their width.
    localparam int QP_MAX = 64;

    function automatic logic [QP_MAX-1:0] quad_apply(
        input logic [QP_MAX-1:0] p,
        input quad_mode_e        mode,
        input int unsigned       trunc
    );
        logic [QP_MAX-1:0] mask;
        mask = ~((64'd1 << trunc) - 64'd1);
        case (mode)
            TRUNC:   quad_apply = p & mask;
            ZERO:    quad_apply = '0;
            default: quad_apply = p;
        endcase
    endfunction

endpackage

// File: rtl/approx_quad_mul.sv
// Combinational HALF x HALF unsigned multiplier with exact/truncated/zeroed result.
// Zero latency; no handshake, the enclosing pipeline owns flow control.
module approx_quad_mul #(
    parameter int HALF    = 4,
    parameter int TRUNC_W = 2
) (
    input  logic [HALF-1:0]   i_x,
    input  logic [HALF-1:0]   i_y,
    input  logic [1:0]        i_mode,
    output logic [2*HALF-1:0] o_p
);
    import approx_mul_pkg::*;

    logic [2*HALF-1:0] w_p;

    assign w_p = (2*HALF)'(i_x) * (2*HALF)'(i_y);
    assign o_p = (2*HALF)'(quad_apply(QP_MAX'(w_p), quad_mode_e'(i_mode), TRUNC_W));

endmodule

// File: rtl/approx_mul_pipe.sv
// 3-stage approximate multiplier: operands/cfg snapshot, quadrant products, sum.
// Latency 3 cycles; global stall, in_ready = ~out_valid | out_ready, all stages hold.
module approx_mul_pipe #(
    parameter int         WIDTH   = 8,
    parameter int         TRUNC   = 2,
    parameter logic [7:0] CFG_RST = 8'h00,
    parameter int         CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [7:0]         cfg_mode_i,
    output logic [7:0]         cfg_mode_o,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic [CNT_W-1:0]   prod_cnt
);
    import approx_mul_pkg::*;

    localparam int HALF = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;

    logic [7:0]         r_cfg;
    logic               r_s1_vld;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [7:0]         r_s1_cfg;
    logic               r_s2_vld;
    logic [WIDTH-1:0]   r_hh;
    logic [WIDTH-1:0]   r_hl;
    logic [WIDTH-1:0]   r_lh;
    logic [WIDTH-1:0]   r_ll;
    logic               r_s3_vld;
    logic [PW-1:0]      r_prod;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_adv;
    logic [HALF-1:0]    w_al;
    logic [HALF-1:0]    w_ah;
    logic [HALF-1:0]    w_bl;
    logic [HALF-1:0]    w_bh;
    logic [WIDTH-1:0]   w_hh;
    logic [WIDTH-1:0]   w_hl;
    logic [WIDTH-1:0]   w_lh;
    logic [WIDTH-1:0]   w_ll;
    logic [PW-1:0]      w_sum;

    assign w_adv      = ~r_s3_vld | out_ready;
    assign in_ready   = w_adv;
    assign out_valid  = r_s3_vld;
    assign prod       = r_prod;
    assign prod_cnt   = r_cnt;
    assign cfg_mode_o = r_cfg;

    assign w_al = r_a[HALF-1:0];
    assign w_ah = r_a[WIDTH-1:HALF];
    assign w_bl = r_b[HALF-1:0];
    assign w_bh = r_b[WIDTH-1:HALF];

    approx_quad_mul #(.HALF(HALF), .TRUNC_W(TRUNC)) u_hh (
        .i_x(w_ah), .i_y(w_bh), .i_mode(r_s1_cfg[CFG_HH +: 2]), .o_p(w_hh)
    );
    approx_quad_mul #(.HALF(HALF), .TRUNC_W(TRUNC)) u_hl (
        .i_x(w_ah), .i_y(w_bl), .i_mode(r_s1_cfg[CFG_HL +: 2]), .o_p(w_hl)
    );
    approx_quad_mul #(.HALF(HALF), .TRUNC_W(TRUNC)) u_lh (
        .i_x(w_al), .i_y(w_bh), .i_mode(r_s1_cfg[CFG_LH +: 2]), .o_p(w_lh)
    );
    approx_quad_mul #(.HALF(HALF), .TRUNC_W(TRUNC)) u_ll (
        .i_x(w_al), .i_y(w_bl), .i_mode(r_s1_cfg[CFG_LL +: 2]), .o_p(w_ll)
    );

    // HL+LH may carry one bit past WIDTH, so the whole sum is done at product width.
    assign w_sum = (PW'(w_hh_q()) << WIDTH)
                 + ((PW'(r_hl) + PW'(r_lh)) << HALF)
                 + PW'(r_ll);

    function automatic logic [WIDTH-1:0] w_hh_q();
        return r_hh;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg <= CFG_RST;
        end else if (cfg_we) begin
            r_cfg <= cfg_mode_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_s1_cfg <= CFG_RST;
            r_s2_vld <= 1'b0;
            r_hh     <= '0;
            r_hl     <= '0;
            r_lh     <= '0;
            r_ll     <= '0;
            r_s3_vld <= 1'b0;
            r_prod   <= '0;
        end else if (w_adv) begin
            r_s1_vld <= in_valid;
            r_a      <= a;
            r_b      <= b;
            r_s1_cfg <= r_cfg;
            r_s2_vld <= r_s1_vld;
            r_hh     <= w_hh;
            r_hl     <= w_hl;
            r_lh     <= w_lh;
            r_ll     <= w_ll;
            r_s3_vld <= r_s2_vld;
            r_prod   <= w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_s3_vld && out_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Scoreboard bench for approx_mul_pipe: directed corner cases plus randomized traffic.
module tb_approx_mul_pipe;

    localparam int W     = 8;
    localparam int HW    = W / 2;
    localparam int TR    = 2;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [7:0]    cfg_mode_i = 8'h00;
    logic [7:0]    cfg_mode_o;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2*W-1:0] prod;
    logic [CW-1:0] prod_cnt;

    int tot = 0;
    int bad = 0;
    int rdy_mode = 0;

    int unsigned    exp_q[$];
    logic [7:0]     m_cfg = 8'h00;
    int unsigned    m_cnt = 0;
    bit             held = 1'b0;
    logic [2*W-1:0] held_val = '0;

    approx_mul_pipe #(.WIDTH(W), .TRUNC(TR), .CFG_RST(8'h00), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mode_i(cfg_mode_i),
        .cfg_mode_o(cfg_mode_o), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .prod_cnt(prod_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp_v);
        tot++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Reference: one half-by-half quadrant under its 2-bit mode.
    function automatic int unsigned quad_ref(input int unsigned x, input int unsigned y,
                                             input int unsigned m);
        int unsigned p;
        p = x * y;
        if (m == 1) return p - (p % (1 << TR));
        if (m == 2) return 0;
        return p;
    endfunction

    function automatic int unsigned prod_ref(input int unsigned av, input int unsigned bv,
                                             input logic [7:0] c);
        int unsigned hb, ah, al, bh, bl;
        hb = 1 << HW;
        ah = av / hb; al = av % hb;
        bh = bv / hb; bl = bv % hb;
        return quad_ref(ah, bh, c[7:6]) * (1 << W)
             + (quad_ref(ah, bl, c[5:4]) + quad_ref(al, bh, c[3:2])) * hb
             + quad_ref(al, bl, c[1:0]);
    endfunction

    always @(posedge clk) begin
        int pc;
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (pc % 3 == 0); pc++; end
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: observes the cycle at the negedge, before the edge that commits it.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_cfg = 8'h00;
            m_cnt = 0;
            held  = 1'b0;
        end else begin
            chk("prod_cnt", prod_cnt, m_cnt % (1 << CW));
            chk("cfg_mode_o", cfg_mode_o, m_cfg);
            chk("in_ready", in_ready, (!out_valid || out_ready));
            if (held) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_prod", prod, held_val);
            end
            held = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", prod, -1);
                end else begin
                    chk("prod", prod, exp_q.pop_front());
                end
                m_cnt++;
            end else if (out_valid) begin
                held     = 1'b1;
                held_val = prod;
            end
            if (in_valid && in_ready) exp_q.push_back(prod_ref(a, b, m_cfg));
            if (cfg_we) m_cfg = cfg_mode_i;
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input bit we, input logic [7:0] wc);
        bit acc;
        int n;
        a = ta; b = tb_v; in_valid = 1'b1;
        cfg_we = we; cfg_mode_i = wc;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            cfg_we = 1'b0;
            n++;
        end while (!acc && n < 200);
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic set_cfg(input logic [7:0] c);
        cfg_we = 1'b1; cfg_mode_i = c;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_prod", prod, 0);
        chk("rst_prod_cnt", prod_cnt, 0);
        chk("rst_cfg", cfg_mode_o, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
    endtask

    // Accept one pair into an empty pipe and expect it exactly three cycles later.
    task automatic direct(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input bit we, input logic [7:0] wc, input logic [2*W-1:0] exp_v);
        drain();
        send(ta, tb_v, we, wc);
        @(negedge clk);
        chk({nm, "_lat1"}, out_valid, 0);
        @(negedge clk);
        chk({nm, "_lat2"}, out_valid, 0);
        @(negedge clk);
        chk({nm, "_lat3"}, out_valid, 1);
        chk(nm, prod, exp_v);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Reset with traffic in flight: nothing stale may come out afterwards.
        set_cfg(8'h55);
        send(8'h21, 8'h43, 1'b0, 8'h00);
        send(8'h87, 8'h65, 1'b0, 8'h00);
        do_reset();
        repeat (6) @(posedge clk);
        #1;

        direct("exact_ff", 8'hFF, 8'hFF, 1'b0, 8'h00, 16'hFE01);
        set_cfg(8'h55);
        direct("trunc_ff", 8'hFF, 8'hFF, 1'b0, 8'h00, 16'hFCE0);
        // Per-quadrant truncation of 0x12*0x34: HH=3->0, HL=4, LH=6->4, LL=8.
        direct("trunc_1234", 8'h12, 8'h34, 1'b0, 8'h00, 16'h0088);
        direct("zero_a", 8'h00, 8'hC3, 1'b0, 8'h00, 16'h0000);
        direct("zero_b", 8'h5A, 8'h00, 1'b0, 8'h00, 16'h0000);
        set_cfg(8'h02);
        direct("zero_ll", 8'hFF, 8'hFF, 1'b0, 8'h00, 16'hFD20);
        set_cfg(8'h00);
        direct("cfg_same_cycle", 8'hFF, 8'hFF, 1'b1, 8'h02, 16'hFE01);
        direct("cfg_after", 8'hFF, 8'hFF, 1'b0, 8'h00, 16'hFD20);

        // Backpressure stream.
        do_reset();
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), 1'b0, 8'h00);
        drain();
        chk("bp_prod_cnt", prod_cnt, 8);

        // Counter wrap with a 4-bit counter.
        rdy_mode = 0;
        do_reset();
        for (int i = 0; i < 17; i++) send(W'($urandom), W'($urandom), 1'b0, 8'h00);
        drain();
        chk("wrap_prod_cnt", prod_cnt, 1);

        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 15) == 0) ra = '0;
            if ($urandom_range(0, 15) == 0) rb = '1;
            send(ra, rb, ($urandom_range(0, 3) == 0), 8'($urandom));
        end
        rdy_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
